// File: rtl/uarc_rx_arbiter_pkg.sv
// Shared types for the UARC receive arbiter: message kind enum and bus-index width helper.
package uarc_pkg;

    typedef enum logic [1:0] {
        KILL   = 2'd0,
        INCEPT = 2'd1,
        SEND   = 2'd2,
        STREAM = 2'd3
    } uarc_kind_t;

    function automatic int bus_idx_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/uarc_rx_arbiter_if.sv
// UARC receive-side bundle: per-bus request/ack/payload lines plus the message queue head.
interface uarc_rx_arbiter_if #(
    parameter int WORD_WIDTH  = 32,
    parameter int TOTAL_BUSES = 32,
    parameter int BUS_IDX_W   = 5,
    parameter int CNT_W       = 3
);
    logic [TOTAL_BUSES-1:0]                 receiver_enable;
    logic [TOTAL_BUSES-1:0]                 receiver_kills, receiver_incepts;
    logic [TOTAL_BUSES-1:0]                 receiver_sends, receiver_streams;
    logic [TOTAL_BUSES-1:0]                 receiver_kill_acks, receiver_incept_acks;
    logic [TOTAL_BUSES-1:0]                 receiver_send_acks, receiver_stream_acks;
    logic [TOTAL_BUSES-1:0][WORD_WIDTH-1:0] receiver_datas;
    logic [TOTAL_BUSES-1:0][WORD_WIDTH-1:0] receiver_self_permissions, receiver_self_addresses;
    logic [TOTAL_BUSES-1:0][WORD_WIDTH-1:0] receiver_incept_permissions, receiver_incept_addresses;

    logic                  msg_valid;
    logic                  msg_ready;
    logic [1:0]            msg_kind;
    logic [BUS_IDX_W-1:0]  msg_bus;
    logic [WORD_WIDTH-1:0] msg_data, msg_self_permission, msg_self_address;
    logic [WORD_WIDTH-1:0] msg_incept_permission, msg_incept_address;
    logic [CNT_W-1:0]      msg_count;

    modport master (
        output receiver_enable, receiver_kills, receiver_incepts, receiver_sends, receiver_streams,
        output receiver_datas, receiver_self_permissions, receiver_self_addresses,
        output receiver_incept_permissions, receiver_incept_addresses, msg_ready,
        input  receiver_kill_acks, receiver_incept_acks, receiver_send_acks, receiver_stream_acks,
        input  msg_valid, msg_kind, msg_bus, msg_data, msg_self_permission, msg_self_address,
        input  msg_incept_permission, msg_incept_address, msg_count
    );

    modport slave (
        input  receiver_enable, receiver_kills, receiver_incepts, receiver_sends, receiver_streams,
        input  receiver_datas, receiver_self_permissions, receiver_self_addresses,
        input  receiver_incept_permissions, receiver_incept_addresses, msg_ready,
        output receiver_kill_acks, receiver_incept_acks, receiver_send_acks, receiver_stream_acks,
        output msg_valid, msg_kind, msg_bus, msg_data, msg_self_permission, msg_self_address,
        output msg_incept_permission, msg_incept_address, msg_count
    );
endinterface

// File: rtl/uarc_rx_arbiter_rr_picker.sv
// Combinational round-robin first-one finder: nearest set request at or after i_start, wrapping.
module uarc_rr_picker #(
    parameter int N     = 32,
    parameter int IDX_W = 5
) (
    input  logic [N-1:0]     i_req,
    input  logic [IDX_W-1:0] i_start,
    output logic             o_found,
    output logic [IDX_W-1:0] o_idx
);
    logic [N-1:0]   w_rot;
    logic [IDX_W:0] w_sum;

    // rotate so bit 0 is the request at i_start
    assign w_rot = N'({i_req, i_req} >> i_start);

    always_comb begin
        o_found = 1'b0;
        w_sum   = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (w_rot[i]) begin
                o_found = 1'b1;
                w_sum   = {1'b0, i_start} + (IDX_W+1)'(i);
            end
        end
        if (w_sum >= (IDX_W+1)'(N)) w_sum = w_sum - (IDX_W+1)'(N);
        o_idx = w_sum[IDX_W-1:0];
    end
endmodule

// File: rtl/uarc_rx_arbiter.sv
// UARC receive arbiter: round-robin grant of one request per cycle into a message FIFO.
// Optional UARC_RX_KILL_FLUSH_EN: a granted kill flushes the queue and bypasses the full check.
module uarc_rx_arbiter
    import uarc_pkg::*;
#(
    parameter int WORD_MAG   = 5,
    parameter int UARC_SETS  = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    uarc_rx_arbiter_if.slave rx
);
    localparam int WORD_WIDTH  = 1 << WORD_MAG;
    localparam int TOTAL_BUSES = UARC_SETS * WORD_WIDTH;
    localparam int BUS_IDX_W   = bus_idx_width(TOTAL_BUSES);
    localparam int PTR_W       = $clog2(FIFO_DEPTH);
    localparam int CNT_W       = PTR_W + 1;

    typedef struct packed {
        uarc_kind_t            kind;
        logic [BUS_IDX_W-1:0]  src;
        logic [WORD_WIDTH-1:0] data;
        logic [WORD_WIDTH-1:0] self_perm;
        logic [WORD_WIDTH-1:0] self_addr;
        logic [WORD_WIDTH-1:0] incept_perm;
        logic [WORD_WIDTH-1:0] incept_addr;
    } uarc_rx_msg_t;

    logic [TOTAL_BUSES-1:0] r_ack_kill, r_ack_incept, r_ack_send, r_ack_stream;
    logic [BUS_IDX_W-1:0]   r_ptr;
    logic                   r_lock;
    uarc_rx_msg_t           r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]       r_wr, r_rd;
    logic [CNT_W-1:0]       r_count;

    logic [TOTAL_BUSES-1:0] w_mask, w_cand, w_ptr_vec, w_req, w_onehot;
    logic                   w_b_en, w_b_mask, w_b_stream_only, w_lock_end, w_locked;
    logic                   w_found, w_full, w_pop, w_grant, w_flush, w_push;
    logic [BUS_IDX_W-1:0]   w_idx, w_ptr_inc;
    uarc_kind_t             w_kind;
    uarc_rx_msg_t           w_entry, w_head;

    // a bus acked this cycle still shows its old request, so keep it out of the race
    assign w_mask = r_ack_kill | r_ack_incept | r_ack_send | r_ack_stream;
    assign w_cand = rx.receiver_enable & ~w_mask &
                    (rx.receiver_kills | rx.receiver_incepts | rx.receiver_sends | rx.receiver_streams);

    always_comb begin
        w_ptr_vec = '0;
        w_onehot  = '0;
        for (int b = 0; b < TOTAL_BUSES; b++) begin
            w_ptr_vec[b] = (r_ptr == BUS_IDX_W'(b));
            w_onehot[b]  = (w_idx == BUS_IDX_W'(b));
        end
    end

    // while locked, r_ptr names the streaming bus
    assign w_b_en          = |(w_ptr_vec & rx.receiver_enable);
    assign w_b_mask        = |(w_ptr_vec & w_mask);
    assign w_b_stream_only = |(w_ptr_vec & rx.receiver_streams & ~rx.receiver_kills &
                               ~rx.receiver_incepts & ~rx.receiver_sends);
    assign w_lock_end      = r_lock & (~w_b_en | (~w_b_mask & ~w_b_stream_only));
    assign w_locked        = r_lock & ~w_lock_end;
    assign w_req           = w_locked ? (w_cand & w_ptr_vec) : w_cand;

    uarc_rr_picker #(.N(TOTAL_BUSES), .IDX_W(BUS_IDX_W)) u_pick (
        .i_req   (w_req),
        .i_start (r_ptr),
        .o_found (w_found),
        .o_idx   (w_idx)
    );

    always_comb begin
        if (rx.receiver_kills[w_idx])        w_kind = KILL;
        else if (rx.receiver_incepts[w_idx]) w_kind = INCEPT;
        else if (rx.receiver_sends[w_idx])   w_kind = SEND;
        else                                 w_kind = STREAM;
    end

    assign w_full    = (r_count == CNT_W'(FIFO_DEPTH));
    assign w_pop     = (r_count != '0) & rx.msg_ready;
    assign w_ptr_inc = (w_idx == BUS_IDX_W'(TOTAL_BUSES - 1)) ? '0 : w_idx + 1'b1;

`ifdef UARC_RX_KILL_FLUSH_EN
    assign w_grant = w_found & (~w_full | w_pop | (w_kind == KILL));
    assign w_flush = w_grant & (w_kind == KILL);
`else
    assign w_grant = w_found & (~w_full | w_pop);
    assign w_flush = 1'b0;
`endif
    assign w_push = w_grant & ~w_flush;

    always_comb begin
        w_entry             = '0;
        w_entry.kind        = w_kind;
        w_entry.src         = w_idx;
        w_entry.data        = rx.receiver_datas[w_idx];
        w_entry.self_perm   = rx.receiver_self_permissions[w_idx];
        w_entry.self_addr   = rx.receiver_self_addresses[w_idx];
        w_entry.incept_perm = rx.receiver_incept_permissions[w_idx];
        w_entry.incept_addr = rx.receiver_incept_addresses[w_idx];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ack_kill   <= '0;
            r_ack_incept <= '0;
            r_ack_send   <= '0;
            r_ack_stream <= '0;
            r_ptr        <= '0;
            r_lock       <= 1'b0;
            r_wr         <= '0;
            r_rd         <= '0;
            r_count      <= '0;
        end else begin
            r_ack_kill   <= '0;
            r_ack_incept <= '0;
            r_ack_send   <= '0;
            r_ack_stream <= '0;
            if (w_grant) begin
                case (w_kind)
                    KILL:    r_ack_kill   <= w_onehot;
                    INCEPT:  r_ack_incept <= w_onehot;
                    SEND:    r_ack_send   <= w_onehot;
                    default: r_ack_stream <= w_onehot;
                endcase
                r_lock <= (w_kind == STREAM);
                r_ptr  <= (w_kind == STREAM) ? w_idx : w_ptr_inc;
            end else begin
                r_lock <= w_locked;
            end
            if (w_flush) begin
                r_rd    <= '0;
                r_wr    <= PTR_W'(1);
                r_count <= CNT_W'(1);
            end else begin
                if (w_push) r_wr <= r_wr + 1'b1;
                if (w_pop)  r_rd <= r_rd + 1'b1;
                r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
            end
        end
    end

    // storage needs no reset: r_count gates every read
    always_ff @(posedge clk) begin
        if (w_flush)     r_mem[0]    <= w_entry;
        else if (w_push) r_mem[r_wr] <= w_entry;
    end

    assign rx.receiver_kill_acks    = r_ack_kill;
    assign rx.receiver_incept_acks  = r_ack_incept;
    assign rx.receiver_send_acks    = r_ack_send;
    assign rx.receiver_stream_acks  = r_ack_stream;

    assign rx.msg_valid             = (r_count != '0);
    assign rx.msg_count             = r_count;
    assign w_head                   = rx.msg_valid ? r_mem[r_rd] : '0;
    assign rx.msg_kind              = w_head.kind;
    assign rx.msg_bus               = w_head.src;
    assign rx.msg_data              = w_head.data;
    assign rx.msg_self_permission   = w_head.self_perm;
    assign rx.msg_self_address      = w_head.self_addr;
    assign rx.msg_incept_permission = w_head.incept_perm;
    assign rx.msg_incept_address    = w_head.incept_addr;
endmodule
